serial_transmit: RTL and testbench
==================================

Name: serial_transmit

Overview:
Parametrised UART transmitter that replaces the fixed 8N1 `transmit` block. Data width, parity mode and stop-bit count are configurable, and a small input FIFO lets the host queue bytes back-to-back. It sits between the host bus logic (stb/dat/rdy handshake) and the external TXD pin.

Parameters:
BAUDRATE, 96e2, line rate in bit/s (real)
FREQUENCY, 12e6, clk frequency in Hz (real); CYCLES = $rtoi(FREQUENCY/BAUDRATE) clocks per bit, must be >= 2
WIDTH, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP, 1, stop bits, legal 1 or 2
DEPTH, 4, FIFO entries, power of 2, >= 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
stb  in  1  host strobe: dat is valid
dat  in  WIDTH  data word, transmitted LSB first
rdy  out  1  FIFO can accept; a word transfers on a posedge where stb && rdy
bsy  out  1  high while a frame is on the line or the FIFO is non-empty
txd  out  1  serial output, idle high (mark)

Behaviour:
- Reset: one clock, synchronous, active-high. While rst is high at a posedge, outputs take these values: txd=1, rdy=0, bsy=0. The FIFO is emptied, the FSM goes to IDLE and the bit counter and cycle counter clear.
- rdy: combinational, equal to !rst_q && !full, where rst_q is rst registered. rdy is therefore 0 in the first cycle after reset deasserts and 1 from the next cycle on.
- Push: on a posedge with stb && rdy, dat is written at the FIFO tail. stb while rdy=0 is ignored; the host must hold stb and dat until it sees rdy. There is no bypass path: every word goes through the FIFO.
- Latency: with the FSM idle and the FIFO empty, a push at edge N causes a pop at edge N+1. txd falls (start bit) at edge N+2.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or -> START directly when the FIFO is non-empty at the end of STOP.
- Bit timing: every state except IDLE lasts exactly CYCLES clocks per bit.
- START: txd=0 for 1 bit.
- DATA: txd = shift[0] for WIDTH bits, LSB first.
- PARITY: present only when PARITY != 0. The bit is ^data for even parity and ~^data for odd parity, computed on the latched word.
- STOP: txd=1 for STOP bits.
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit period. There is no extra idle bit between frames.
- Pop: happens in IDLE, or in the last cycle of STOP, when the FIFO is non-empty. The word is latched into the shift register at that point.
- Simultaneous push and pop while full: the pop frees a slot, but rdy was 0 in that cycle, so no push occurs. rdy rises on the next cycle.
- FIFO pointers: log2(DEPTH)+1 bits wide and wrap naturally. full = MSBs differ and LSBs equal; empty = pointers equal.
- bsy = (state != IDLE) || !empty.
- Reset mid-frame: the frame is aborted. txd is 1 from the reset edge onward and queued words are discarded.

Optional Feature:
- Macro: SERIAL_TRANSMIT_BREAK_EN.
- With the macro: an extra input brk (1 bit) and an extra FSM state BREAK.
  - brk is sampled in IDLE and takes priority over a pending pop.
  - In BREAK, txd=0 for at least (1+WIDTH+(PARITY!=0)+STOP) bit periods and until brk is low at a bit boundary.
  - BREAK is followed by 1 bit period of mark (STOP state), then IDLE.
  - The FIFO keeps accepting words during BREAK; bsy=1 during BREAK.
- Without the macro: no brk port, no BREAK state, and the logic is identical otherwise.

Decomposition:
- serial_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the parity constants PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2;
  - a function cycles_per_bit(real freq, real baud) returning an int.
- One sub-module, serial_fifo (parameters WIDTH and DEPTH; ports clk, rst, push, pop, din, dout, full, empty), synchronous, with first-word dout valid while !empty.

Test Plan:
- Defaults (CYCLES=1250): push 8'h55 then 8'haa. Each frame samples at mid-bit as start=0, data LSB first, stop=1; the decoded values are 8'h55 and 8'haa. txd falls 2 clocks after the accepting edge.
- Burst: push 5 words with DEPTH=4. rdy drops after the 4th queued word and reasserts when the first pop occurs. All 5 frames are received in order, with no idle time between a stop bit and the next start bit.
- WIDTH=7, PARITY=2, STOP=2, data 7'h43: line sequence is 0, 1100001 (LSB first), parity 1, then 1, 1.
- PARITY=1 with data 8'h00: parity bit is 1. PARITY=1 with data 8'h01: parity bit is 0.
- Assert rst for 1 cycle in the middle of the DATA bits with 2 words queued: txd=1 on the next cycle, bsy=0, and nothing further is transmitted. rdy=0 for one cycle, then 1.
- With SERIAL_TRANSMIT_BREAK_EN, hold brk for 3 clocks in IDLE: txd stays low for exactly 10*CYCLES clocks (8N1), then high for CYCLES clocks, then a queued 8'h3c transmits correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial transmitter: FSM states, parity modes and bit timing.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int cycles_per_bit(input real freq, input real baud);
        return $rtoi(freq / baud);
    endfunction

    // Line parity bit for a word zero-extended to the widest legal frame
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        logic p;
        case (mode)
            PARITY_ODD:  p = ~^data;
            PARITY_EVEN: p = ^data;
            default:     p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/serial_fifo.sv
// Synchronous FIFO with wrap-bit pointers; the head word is presented on dout whenever !empty.
module serial_fifo
    import serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             wr_en_s;
    logic             rd_en_s;

    assign wr_en_s = push && !full;
    assign rd_en_s = pop && !empty;

    // Pointer advance; the extra MSB distinguishes full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r[AW-1:0]];
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

endmodule

// File: rtl/serial_transmit.sv
// Parametrised UART transmitter: host stb/dat/rdy handshake into a FIFO, framed onto txd.
// Line-break generation (brk input, BREAK state) is compiled in with SERIAL_TRANSMIT_BREAK_EN.
module serial_transmit
    import serial_pkg::*;
#(
    parameter real BAUDRATE  = 96e2,
    parameter real FREQUENCY = 12e6,
    parameter int  WIDTH     = 8,
    parameter int  PARITY    = 0,
    parameter int  STOP      = 1,
    parameter int  DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stb,
    input  logic [WIDTH-1:0] dat,
`ifdef SERIAL_TRANSMIT_BREAK_EN
    input  logic             brk,
`endif
    output logic             rdy,
    output logic             bsy,
    output logic             txd
);

    localparam int CYCLES  = cycles_per_bit(FREQUENCY, BAUDRATE);
    localparam int CW      = $clog2(CYCLES);
    localparam int HAS_PAR = (PARITY != PARITY_NONE) ? 1 : 0;

    localparam logic [CW-1:0] CYC_LAST  = CW'(CYCLES - 1);
    localparam logic [CW-1:0] CYC_ONE   = CW'(1'b1);
    localparam logic [3:0]    BIT_ONE   = 4'd1;
    localparam logic [3:0]    DATA_LAST = 4'(WIDTH - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP - 1);
`ifdef SERIAL_TRANSMIT_BREAK_EN
    localparam int            FRAME_BITS = 1 + WIDTH + HAS_PAR + STOP;
    localparam logic [3:0]    BRK_LAST   = 4'(FRAME_BITS - 1);
`endif

    state_t           state_r;
    logic [CW-1:0]    cyc_r;
    logic [3:0]       bit_r;
    logic [WIDTH-1:0] shift_r;
    logic             par_r;
    logic             txd_r;
    logic             rst_q_r;

    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic [WIDTH-1:0] fifo_dout_s;
    logic             bit_end_s;
    logic             line_s;

    assign push_s    = stb && rdy;
    assign bit_end_s = (cyc_r == CYC_LAST);

    serial_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (dat),
        .dout  (fifo_dout_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Pop decision: from IDLE, or on the final cycle of the last stop bit for gapless frames
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
`ifdef SERIAL_TRANSMIT_BREAK_EN
                pop_s = !empty_s && !brk;
`else
                pop_s = !empty_s;
`endif
            end
            ST_STOP: begin
                if (bit_end_s && (bit_r == STOP_LAST)) begin
                    pop_s = !empty_s;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: pop_s = 1'b0;
        endcase
    end

    // Line level belonging to the current state; registered one clock later into txd
    always_comb begin
        line_s = 1'b1;
        case (state_r)
            ST_IDLE:   line_s = 1'b1;
            ST_START:  line_s = 1'b0;
            ST_DATA:   line_s = shift_r[0];
            ST_PARITY: line_s = par_r;
            ST_STOP:   line_s = 1'b1;
            ST_BREAK:  line_s = 1'b0;
            default:   line_s = 1'b1;
        endcase
    end

    // Registered copy of reset so rdy stays low for the first cycle after release
    always_ff @(posedge clk) begin
        rst_q_r <= rst;
    end

    // Frame sequencer: state, bit and cycle counters, shift register and line output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cyc_r   <= '0;
            bit_r   <= 4'd0;
            shift_r <= '0;
            par_r   <= 1'b0;
            txd_r   <= 1'b1;
        end else begin
            txd_r <= line_s;
            if ((state_r == ST_IDLE) || bit_end_s) begin
                cyc_r <= '0;
            end else begin
                cyc_r <= cyc_r + CYC_ONE;
            end
            case (state_r)
                ST_IDLE: begin
                    bit_r <= 4'd0;
`ifdef SERIAL_TRANSMIT_BREAK_EN
                    if (brk) begin
                        state_r <= ST_BREAK;
                    end else
`endif
                    if (pop_s) begin
                        shift_r <= fifo_dout_s;
                        par_r   <= parity_bit(9'(fifo_dout_s), PARITY);
                        state_r <= ST_START;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        bit_r   <= 4'd0;
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        shift_r <= {1'b0, shift_r[WIDTH-1:1]};
                        if (bit_r == DATA_LAST) begin
                            bit_r   <= 4'd0;
                            state_r <= (HAS_PAR != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_r <= bit_r + BIT_ONE;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) begin
                        bit_r   <= 4'd0;
                        state_r <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        if (bit_r == STOP_LAST) begin
                            bit_r <= 4'd0;
                            if (pop_s) begin
                                shift_r <= fifo_dout_s;
                                par_r   <= parity_bit(9'(fifo_dout_s), PARITY);
                                state_r <= ST_START;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            bit_r <= bit_r + BIT_ONE;
                        end
                    end
                end
`ifdef SERIAL_TRANSMIT_BREAK_EN
                ST_BREAK: begin
                    // Minimum one full frame of space, then wait for brk low at a bit boundary
                    if (bit_end_s) begin
                        if ((bit_r >= BRK_LAST) && !brk) begin
                            bit_r   <= STOP_LAST;
                            state_r <= ST_STOP;
                        end else if (bit_r < BRK_LAST) begin
                            bit_r <= bit_r + BIT_ONE;
                        end else begin
                            bit_r <= bit_r;
                        end
                    end
                end
`endif
                default: begin
                    bit_r   <= 4'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdy = !rst_q_r && !full_s;
    assign bsy = (state_r != ST_IDLE) || !empty_s;
    assign txd = txd_r;

endmodule

// File: tb/tb_serial_transmit.sv
// Bench for serial_transmit: three configurations under random traffic, each checked every
// cycle against a frame-level model that expands queued words into expected line samples.
`timescale 1ns/1ps
module tb_serial_transmit;

    localparam int N = 3;
    localparam int W_P [N] = '{8, 7, 8};
    localparam int P_P [N] = '{0, 2, 1};
    localparam int S_P [N] = '{1, 2, 1};
    localparam int C_P [N] = '{5, 3, 4};
    localparam int D_P [N] = '{4, 4, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic       stb [N];
    logic [8:0] dat [N];
    logic       rdy [N];
    logic       bsy [N];
    logic       txd [N];
`ifdef SERIAL_TRANSMIT_BREAK_EN
    logic       brk;
`endif

    int         n_cmp;
    int         n_err;
    bit         chk_on = 1'b0;
    bit         rstq_m = 1'b0;
    bit         wave_q [N][$];
    logic [8:0] fifo_q [N][$];
    logic [8:0] dq     [N][$];
    bit         exp_txd [N];
    bit         exp_bsy [N];
    bit         acc     [N];

    always #5 clk = ~clk;

    serial_transmit #(.BAUDRATE(10.0), .FREQUENCY(50.0), .WIDTH(8), .PARITY(0), .STOP(1), .DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .stb(stb[0]), .dat(dat[0][7:0]),
`ifdef SERIAL_TRANSMIT_BREAK_EN
        .brk(brk),
`endif
        .rdy(rdy[0]), .bsy(bsy[0]), .txd(txd[0]));

    serial_transmit #(.BAUDRATE(10.0), .FREQUENCY(30.0), .WIDTH(7), .PARITY(2), .STOP(2), .DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .stb(stb[1]), .dat(dat[1][6:0]),
`ifdef SERIAL_TRANSMIT_BREAK_EN
        .brk(brk),
`endif
        .rdy(rdy[1]), .bsy(bsy[1]), .txd(txd[1]));

    serial_transmit #(.BAUDRATE(10.0), .FREQUENCY(40.0), .WIDTH(8), .PARITY(1), .STOP(1), .DEPTH(2)) u2 (
        .clk(clk), .rst(rst), .stb(stb[2]), .dat(dat[2][7:0]),
`ifdef SERIAL_TRANSMIT_BREAK_EN
        .brk(brk),
`endif
        .rdy(rdy[2]), .bsy(bsy[2]), .txd(txd[2]));

    function automatic int flen(input int i);
        return 1 + W_P[i] + ((P_P[i] != 0) ? 1 : 0) + S_P[i];
    endfunction

    // Line bits of one frame, bit k = k-th bit on the wire; parity from a count of ones
    function automatic logic [15:0] frame_vec(input int w, input int p, input int s, input logic [8:0] d);
        logic [15:0] v;
        int k;
        int ones;
        v = 16'h0000;
        k = 1;
        ones = 0;
        for (int b = 0; b < w; b++) begin
            v[k] = d[b];
            ones += int'(d[b]);
            k++;
        end
        if (p != 0) begin
            v[k] = (p == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
            k++;
        end
        for (int b = 0; b < s; b++) begin
            v[k] = 1'b1;
            k++;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame starts when the line is idle or in its last sample and a word is queued
    always @(posedge clk) begin : model
        bit         rdy_b;
        bit         do_pop;
        bit         do_brk;
        logic [15:0] v;
        logic [8:0]  w;
        for (int i = 0; i < N; i++) begin
            acc[i] = 1'b0;
            if (rst) begin
                wave_q[i].delete();
                fifo_q[i].delete();
                exp_txd[i] = 1'b1;
            end else begin
                rdy_b  = !rstq_m && (fifo_q[i].size() < D_P[i]);
                do_brk = 1'b0;
`ifdef SERIAL_TRANSMIT_BREAK_EN
                do_brk = brk && (wave_q[i].size() == 0);
`endif
                do_pop = !do_brk && (fifo_q[i].size() > 0) && (wave_q[i].size() <= 1);
                exp_txd[i] = (wave_q[i].size() > 0) ? wave_q[i].pop_front() : 1'b1;
                if (do_brk) begin
                    for (int k = 0; k < flen(i) * C_P[i]; k++) wave_q[i].push_back(1'b0);
                    for (int k = 0; k < C_P[i]; k++) wave_q[i].push_back(1'b1);
                end
                if (do_pop) begin
                    w = fifo_q[i].pop_front();
                    v = frame_vec(W_P[i], P_P[i], S_P[i], w);
                    for (int b = 0; b < flen(i); b++)
                        for (int c = 0; c < C_P[i]; c++) wave_q[i].push_back(v[b]);
                end
                if (stb[i] && rdy_b) begin
                    fifo_q[i].push_back(dat[i] & 9'((32'd1 << W_P[i]) - 32'd1));
                    acc[i] = 1'b1;
                end
            end
            exp_bsy[i] = (wave_q[i].size() > 0) || (fifo_q[i].size() > 0);
        end
        rstq_m = rst;
        if (rst) chk_on = 1'b1;
    end

    // Every output of every instance against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("txd%0d", i), {15'd0, txd[i]}, {15'd0, exp_txd[i]});
                check($sformatf("bsy%0d", i), {15'd0, bsy[i]}, {15'd0, exp_bsy[i]});
                check($sformatf("rdy%0d", i), {15'd0, rdy[i]},
                      {15'd0, (!rstq_m && (fifo_q[i].size() < D_P[i]))});
            end
        end
    end

    task automatic drive(input int pct);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!stb[i] || acc[i]) begin
                if (dq[i].size() > 0) begin
                    stb[i] = 1'b1;
                    dat[i] = dq[i].pop_front();
                end else if ($urandom_range(99) < pct) begin
                    stb[i] = 1'b1;
                    dat[i] = 9'($urandom_range((1 << W_P[i]) - 1, 0));
                end else begin
                    stb[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic stb_off();
        for (int i = 0; i < N; i++) stb[i] = 1'b0;
    endtask

    initial begin
        bit found;
        bit idle;
        int run;
        bit seen_low;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
`ifdef SERIAL_TRANSMIT_BREAK_EN
        brk = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            stb[i] = 1'b0;
            dat[i] = 9'h000;
        end
        dq[0].push_back(9'h055);
        dq[0].push_back(9'h0aa);
        dq[0].push_back(9'h011);
        dq[0].push_back(9'h022);
        dq[0].push_back(9'h033);
        dq[0].push_back(9'h044);
        dq[0].push_back(9'h0ff);
        dq[1].push_back(9'h043);
        dq[2].push_back(9'h000);
        dq[2].push_back(9'h001);

        check("pin_8n1_55", frame_vec(8, 0, 1, 9'h055), 16'h02aa);
        check("pin_8n1_aa", frame_vec(8, 0, 1, 9'h0aa), 16'h0354);
        check("pin_7e2_43", frame_vec(7, 2, 2, 9'h043), 16'h0786);
        check("pin_8o1_00", frame_vec(8, 1, 1, 9'h000), 16'h0600);
        check("pin_8o1_01", frame_vec(8, 1, 1, 9'h001), 16'h0402);

        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 1500; t++) drive(100);
        for (int t = 0; t < 1500; t++) drive(((t % 300) < 150) ? 20 : 70);

        // Abort a frame part-way through its data bits while words are still queued
        found = 1'b0;
        for (int t = 0; (t < 2000) && !found; t++) begin
            drive(90);
            if ((fifo_q[0].size() >= 2) &&
                (wave_q[0].size() >= (flen(0) - 6) * C_P[0]) &&
                (wave_q[0].size() <= (flen(0) - 3) * C_P[0]))
                found = 1'b1;
        end
        check("midrst_reached", {15'd0, found}, 16'd1);
        rst = 1'b1;
        stb_off();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        for (int t = 0; t < 1500; t++) drive(60);

        stb_off();
        idle = 1'b0;
        for (int t = 0; (t < 4000) && !idle; t++) begin
            @(negedge clk);
            idle = !exp_bsy[0] && !exp_bsy[1] && !exp_bsy[2];
        end
        check("drain", {15'd0, idle}, 16'd1);

`ifdef SERIAL_TRANSMIT_BREAK_EN
        @(negedge clk);
        brk = 1'b1;
        stb[0] = 1'b1;
        dat[0] = 9'h03c;
        @(negedge clk);
        stb[0] = 1'b0;
        repeat (2) @(negedge clk);
        brk = 1'b0;
        run = 0;
        seen_low = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (txd[0] === 1'b0) begin
                run++;
                seen_low = 1'b1;
            end else if (seen_low) begin
                break;
            end
            @(negedge clk);
        end
        check("brk_low_len", 16'(run), 16'd50);
        idle = 1'b0;
        for (int t = 0; (t < 2000) && !idle; t++) begin
            @(negedge clk);
            idle = !exp_bsy[0] && !exp_bsy[1] && !exp_bsy[2];
        end
        check("brk_drain", {15'd0, idle}, 16'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
